// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the MIPS datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unsupported encodings raise sticky `illegal` and halt until reset.
module mips_ctrl_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         CNT_W       = 32
) (
    input  logic             RF_CLK,
    input  logic             reset,
    input  logic [31:0]      imem_data,
    input  logic             imem_valid,
    input  logic             z,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic [31:0]      inst,
    output logic [4:0]       Rsc,
    output logic [4:0]       Rtc,
    output logic [4:0]       Rdc,
    output logic [3:0]       aluc,
    output logic             M1,
    output logic             M2,
    output logic             M3,
    output logic             M4,
    output logic             M5,
    output logic             M6,
    output logic             M7,
    output logic             M8,
    output logic             M9,
    output logic             sign,
    output logic             RF_W,
    output logic             pc_ena,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RALU = 4'd0,
        C_IALU = 4'd1,
        C_LW   = 4'd2,
        C_SW   = 4'd3,
        C_BEQ  = 4'd4,
        C_BNE  = 4'd5,
        C_J    = 4'd6,
        C_JAL  = 4'd7,
        C_JR   = 4'd8,
        C_BAD  = 4'd9
    } cls_t;

    state_t           state_r;
    state_t           nxt_state_s;
    logic [31:0]      ir_r;
    logic [CNT_W-1:0] retired_r;
    logic [5:0]       op_s;
    logic [5:0]       funct_s;
    cls_t             cls_s;
    logic [3:0]       dec_aluc_s;
    logic             dec_sign_s;
    logic             shift_s;
    logic             ir_load_s;
    logic             imem_req_s;
    logic             rf_w_s;
    logic             pc_ena_s;
    logic             dmem_re_s;
    logic             dmem_we_s;
    logic [9:1]       m_s;
    logic [3:0]       aluc_s;
    logic             sign_s;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             trap_s;
    logic             illegal_r;
`endif

    assign op_s    = ir_r[31:26];
    assign funct_s = ir_r[5:0];

    // Instruction classification and per-opcode ALU function / immediate extension.
    always_comb begin
        cls_s      = C_BAD;
        dec_aluc_s = 4'b0000;
        dec_sign_s = 1'b1;
        shift_s    = 1'b0;
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h21: begin cls_s = C_RALU; dec_aluc_s = 4'b0000; end
                    6'h23: begin cls_s = C_RALU; dec_aluc_s = 4'b0001; end
                    6'h24: begin cls_s = C_RALU; dec_aluc_s = 4'b0100; end
                    6'h25: begin cls_s = C_RALU; dec_aluc_s = 4'b0101; end
                    6'h26: begin cls_s = C_RALU; dec_aluc_s = 4'b0110; end
                    6'h27: begin cls_s = C_RALU; dec_aluc_s = 4'b0111; end
                    6'h2A: begin cls_s = C_RALU; dec_aluc_s = 4'b1011; end
                    6'h2B: begin cls_s = C_RALU; dec_aluc_s = 4'b1010; end
                    6'h00: begin cls_s = C_RALU; dec_aluc_s = 4'b1110; shift_s = 1'b1; end
                    6'h02: begin cls_s = C_RALU; dec_aluc_s = 4'b1101; shift_s = 1'b1; end
                    6'h03: begin cls_s = C_RALU; dec_aluc_s = 4'b1100; shift_s = 1'b1; end
                    6'h08: begin cls_s = C_JR; end
                    default: begin cls_s = C_BAD; end
                endcase
            end
            6'h09: begin cls_s = C_IALU; dec_aluc_s = 4'b0000; end
            6'h0C: begin cls_s = C_IALU; dec_aluc_s = 4'b0100; dec_sign_s = 1'b0; end
            6'h0D: begin cls_s = C_IALU; dec_aluc_s = 4'b0101; dec_sign_s = 1'b0; end
            6'h0E: begin cls_s = C_IALU; dec_aluc_s = 4'b0110; dec_sign_s = 1'b0; end
            6'h0F: begin cls_s = C_IALU; dec_aluc_s = 4'b1000; end
            6'h0A: begin cls_s = C_IALU; dec_aluc_s = 4'b1011; end
            6'h0B: begin cls_s = C_IALU; dec_aluc_s = 4'b1010; end
            6'h23: begin cls_s = C_LW;   dec_aluc_s = 4'b0000; end
            6'h2B: begin cls_s = C_SW;   dec_aluc_s = 4'b0000; end
            6'h04: begin cls_s = C_BEQ;  dec_aluc_s = 4'b0001; end
            6'h05: begin cls_s = C_BNE;  dec_aluc_s = 4'b0001; end
            6'h02: begin cls_s = C_J;    end
            6'h03: begin cls_s = C_JAL;  end
            default: begin cls_s = C_BAD; end
        endcase
    end

    // Next-state logic and single-cycle strobes.
    always_comb begin
        nxt_state_s = state_r;
        ir_load_s   = 1'b0;
        imem_req_s  = 1'b0;
        rf_w_s      = 1'b0;
        pc_ena_s    = 1'b0;
        dmem_re_s   = 1'b0;
        dmem_we_s   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_s      = 1'b0;
`endif
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_valid) begin
                    ir_load_s   = 1'b1;
                    nxt_state_s = ST_DECODE;
                end else begin
                    nxt_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (cls_s == C_BAD) begin
                    trap_s      = 1'b1;
                    nxt_state_s = ST_HALT;
                end else begin
                    nxt_state_s = ST_EXEC;
                end
`else
                nxt_state_s = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                case (cls_s)
                    C_RALU, C_IALU, C_JAL: nxt_state_s = ST_WB;
                    C_LW, C_SW:            nxt_state_s = ST_MEM;
                    // Branches, jumps and untrapped unsupported encodings retire here.
                    default: begin
                        pc_ena_s    = 1'b1;
                        nxt_state_s = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                dmem_re_s = (cls_s == C_LW);
                dmem_we_s = (cls_s != C_LW);
                if (dmem_ack) begin
                    if (cls_s == C_LW) begin
                        nxt_state_s = ST_WB;
                    end else begin
                        pc_ena_s    = 1'b1;
                        nxt_state_s = ST_FETCH;
                    end
                end else begin
                    nxt_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_w_s      = 1'b1;
                pc_ena_s    = 1'b1;
                nxt_state_s = ST_FETCH;
            end
            ST_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                nxt_state_s = ST_HALT;
`else
                nxt_state_s = ST_FETCH;
`endif
            end
            default: nxt_state_s = ST_FETCH;
        endcase
    end

    // Datapath selects: idle value (all ones) outside DECODE..WB, IR-driven inside.
    always_comb begin
        m_s    = 9'b1_1111_1111;
        aluc_s = 4'b0000;
        sign_s = 1'b0;
        case (state_r)
            ST_DECODE, ST_EXEC, ST_MEM, ST_WB: begin
                m_s[5] = 1'b0;
                aluc_s = dec_aluc_s;
                sign_s = dec_sign_s;
                case (cls_s)
                    C_RALU: begin m_s[4] = 1'b0; m_s[6] = 1'b0; m_s[3] = ~shift_s; end
                    C_LW:   m_s[2] = 1'b0;
                    C_BEQ:  begin m_s[4] = 1'b0; m_s[5] = z; end
                    C_BNE:  begin m_s[4] = 1'b0; m_s[5] = ~z; end
                    C_J:    m_s[1] = 1'b0;
                    C_JAL:  begin m_s[1] = 1'b0; m_s[6] = 1'b0; m_s[8] = 1'b0; m_s[9] = 1'b0; end
                    C_JR:   begin m_s[7] = 1'b0; m_s[4] = 1'b0; m_s[6] = 1'b0; end
                    default: m_s[5] = 1'b0;
                endcase
            end
            default: begin
                m_s    = 9'b1_1111_1111;
                aluc_s = 4'b0000;
                sign_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge RF_CLK) begin
        if (reset) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Instruction register, loaded on the accepted fetch beat.
    always_ff @(posedge RF_CLK) begin
        if (reset) begin
            ir_r <= 32'h0000_0000;
        end else if (ir_load_s) begin
            ir_r <= imem_data;
        end
    end

    // Retired-instruction counter, one per PC update, wraps naturally.
    always_ff @(posedge RF_CLK) begin
        if (reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (pc_ena_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-encoding flag, cleared only by reset.
    always_ff @(posedge RF_CLK) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (trap_s) begin
            illegal_r <= 1'b1;
        end
    end
    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    // Reset forces strobes low and selects to their idle value in the reset cycle itself.
    assign imem_req = imem_req_s & ~reset;
    assign RF_W     = rf_w_s     & ~reset;
    assign pc_ena   = pc_ena_s   & ~reset;
    assign dmem_re  = dmem_re_s  & ~reset;
    assign dmem_we  = dmem_we_s  & ~reset;
    assign {M9, M8, M7, M6, M5, M4, M3, M2, M1} = m_s | {9{reset}};
    assign aluc     = reset ? 4'b0000 : aluc_s;
    assign sign     = sign_s & ~reset;

    assign inst    = ir_r;
    assign Rsc     = ir_r[25:21];
    assign Rtc     = ir_r[20:16];
    assign Rdc     = ir_r[15:11];
    assign retired = retired_r;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Scoreboard bench for mips_ctrl_fsm: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every pc_ena pulse.
module tb_mips_ctrl_fsm;

    logic        RF_CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_data = 32'h0000_0000;
    logic        imem_valid = 1'b0;
    logic        z = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req;
    logic [31:0] inst;
    logic [4:0]  Rsc, Rtc, Rdc;
    logic [3:0]  aluc;
    logic        M1, M2, M3, M4, M5, M6, M7, M8, M9;
    logic        sign, RF_W, pc_ena, dmem_re, dmem_we, illegal;
    logic [31:0] retired;
    wire  [9:1]  m_bus = {M9, M8, M7, M6, M5, M4, M3, M2, M1};

    mips_ctrl_fsm dut (
        .RF_CLK(RF_CLK), .reset(reset), .imem_data(imem_data), .imem_valid(imem_valid),
        .z(z), .dmem_ack(dmem_ack), .imem_req(imem_req), .inst(inst),
        .Rsc(Rsc), .Rtc(Rtc), .Rdc(Rdc), .aluc(aluc),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6), .M7(M7), .M8(M8), .M9(M9),
        .sign(sign), .RF_W(RF_W), .pc_ena(pc_ena), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .retired(retired), .illegal(illegal)
    );

    always #5 RF_CLK = ~RF_CLK;

    typedef struct {
        string name;
        int    lat;
        int    rfw;
        int    dre;
        int    dwe;
        int    aluc;
        int    m;
        int    sgn;
        int    ret;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_ret = 0;
    int   dmem_wait = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: accumulate per-instruction strobe counts, compare at each pc_ena.
    initial begin
        int   cyc, rfw_n, dre_n, dwe_n;
        exp_t e;
        cyc = 0; rfw_n = 0; dre_n = 0; dwe_n = 0;
        forever begin
            @(negedge RF_CLK);
            if (reset) begin
                cyc = 0; rfw_n = 0; dre_n = 0; dwe_n = 0;
            end else begin
                cyc++;
                rfw_n += int'(RF_W);
                dre_n += int'(dmem_re);
                dwe_n += int'(dmem_we);
                if (pc_ena) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pc_ena", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk({e.name, "_latency"}, cyc, e.lat);
                        chk({e.name, "_RF_W_last"}, int'(RF_W), e.rfw);
                        chk({e.name, "_RF_W_cycles"}, rfw_n, e.rfw);
                        chk({e.name, "_dmem_re_cycles"}, dre_n, e.dre);
                        chk({e.name, "_dmem_we_cycles"}, dwe_n, e.dwe);
                        chk({e.name, "_aluc"}, int'(aluc), e.aluc);
                        chk({e.name, "_M9toM1"}, int'(m_bus), e.m);
                        chk({e.name, "_sign"}, int'(sign), e.sgn);
                        chk({e.name, "_retired"}, int'(retired), e.ret);
                    end
                    cyc = 0; rfw_n = 0; dre_n = 0; dwe_n = 0;
                end
            end
        end
    end

    // Data-memory responder: ack after dmem_wait stalled cycles, settled after the edge.
    initial begin
        int mc;
        mc = 0;
        forever begin
            @(posedge RF_CLK);
            #2;
            if (dmem_re || dmem_we) begin
                dmem_ack = (mc == dmem_wait);
                mc++;
            end else begin
                dmem_ack = 1'b0;
                mc = 0;
            end
        end
    end

    task automatic fetch(input string nm, input logic [31:0] instr, input int iw, input logic zv);
        z = zv;
        for (int i = 0; i < iw; i++) begin
            imem_valid = 1'b0;
            @(negedge RF_CLK);
            chk({nm, "_imem_req_wait"}, int'(imem_req), 1);
            @(posedge RF_CLK);
            #1;
        end
        imem_data  = instr;
        imem_valid = 1'b1;
        @(negedge RF_CLK);
        chk({nm, "_imem_req"}, int'(imem_req), 1);
        @(posedge RF_CLK);
        #1;
        imem_valid = 1'b0;
        imem_data  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done(input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge RF_CLK);
            if (pc_ena) done = 1'b1;
        end
        chk({nm, "_completes"}, int'(done), 1);
        @(posedge RF_CLK);
        #1;
    endtask

    task automatic issue(input string nm, input logic [31:0] instr, input int iw, input int dw,
                         input logic zv, input int lat, input int rfw, input int dre, input int dwe,
                         input logic [3:0] al, input logic [9:1] m, input logic sg);
        exp_t e;
        e.name = nm; e.lat = lat; e.rfw = rfw; e.dre = dre; e.dwe = dwe;
        e.aluc = int'(al); e.m = int'(m); e.sgn = int'(sg); e.ret = exp_ret;
        sb_q.push_back(e);
        exp_ret++;
        dmem_wait = dw;
        fetch(nm, instr, iw, zv);
        wait_done(nm);
    endtask

    initial begin
        reset = 1'b1;
        @(negedge RF_CLK);
        chk("rst_RF_W", int'(RF_W), 0);
        chk("rst_pc_ena", int'(pc_ena), 0);
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_dmem", int'(dmem_re | dmem_we), 0);
        @(negedge RF_CLK);
        chk("rst_retired", int'(retired), 0);
        chk("rst_M9toM1", int'(m_bus), 32'h1FF);
        chk("rst_aluc", int'(aluc), 0);
        chk("rst_sign", int'(sign), 0);
        chk("rst_inst", int'(inst), 0);
        chk("rst_illegal", int'(illegal), 0);
        @(posedge RF_CLK);
        #1;
        reset = 1'b0;

        //     name     instr         iw dw z  lat rfw dre dwe aluc     M9..M1        sign
        issue("addu",  32'h00221821, 0, 0, 0, 4,  1,  0,  0,  4'b0000, 9'b111000111, 1'b1);
        issue("lw",    32'h8C040008, 0, 3, 0, 8,  1,  4,  0,  4'b0000, 9'b111101101, 1'b1);
        issue("beq",   32'h10210004, 0, 0, 1, 3,  0,  0,  0,  4'b0001, 9'b111110111, 1'b1);
        issue("bne",   32'h14210004, 0, 0, 1, 3,  0,  0,  0,  4'b0001, 9'b111100111, 1'b1);
        issue("ori",   32'h34051234, 2, 0, 0, 6,  1,  0,  0,  4'b0101, 9'b111101111, 1'b0);
        issue("sw",    32'hAC04000C, 0, 1, 0, 5,  0,  0,  2,  4'b0000, 9'b111101111, 1'b1);
        issue("sra",   32'h000230C3, 0, 0, 0, 4,  1,  0,  0,  4'b1100, 9'b111000011, 1'b1);
        issue("j",     32'h08000040, 0, 0, 0, 3,  0,  0,  0,  4'b0000, 9'b111101110, 1'b1);
        issue("jr",    32'h03E00008, 0, 0, 0, 3,  0,  0,  0,  4'b0000, 9'b110000111, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        begin
            int pulses;
            pulses = 0;
            fetch("illegal", 32'hFC000000, 0, 1'b0);
            for (int k = 0; k < 6; k++) begin
                @(negedge RF_CLK);
                pulses += int'(pc_ena | RF_W | imem_req);
            end
            chk("trap_illegal", int'(illegal), 1);
            chk("trap_no_strobes", pulses, 0);
            chk("trap_retired_frozen", int'(retired), exp_ret);
            @(posedge RF_CLK);
            #1;
            reset = 1'b1;
            @(posedge RF_CLK);
            #1;
            reset = 1'b0;
            exp_ret = 0;
        end
`else
        issue("nop",   32'hFC000000, 0, 0, 0, 3,  0,  0,  0,  4'b0000, 9'b111101111, 1'b1);
`endif
        issue("jal",   32'h0C000040, 0, 0, 0, 4,  1,  0,  0,  4'b0000, 9'b001001110, 1'b1);

        // Reset during EXEC of a taken beq: no strobes in that cycle, back to FETCH.
        fetch("beq_abort", 32'h10210004, 0, 1'b1);
        @(posedge RF_CLK);
        #1;
        reset = 1'b1;
        @(negedge RF_CLK);
        chk("abort_pc_ena", int'(pc_ena), 0);
        chk("abort_RF_W", int'(RF_W), 0);
        chk("abort_dmem", int'(dmem_re | dmem_we), 0);
        chk("abort_M9toM1", int'(m_bus), 32'h1FF);
        @(posedge RF_CLK);
        #1;
        reset = 1'b0;
        exp_ret = 0;

        issue("addu2", 32'h00221821, 0, 0, 0, 4,  1,  0,  0,  4'b0000, 9'b111000111, 1'b1);

        @(negedge RF_CLK);
        chk("final_retired", int'(retired), exp_ret);
        chk("final_illegal", int'(illegal), 0);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
